zap_mmu_wb_arbiter: RTL and testbench

Two-master Wishbone arbiter that merges the page-table walker's descriptor reads and the cache controller's line fills and write-backs onto the single external Wishbone port. It sits directly downstream of the TLB walk FSM and the cache FSM. Both masters present `*_nxt` request signals. The arbiter registers the selected master's `*_nxt` set, so its bus outputs are cycle-aligned with each master's own flopped copy. Ownership is held for a master's whole CYC window, so bursts are never split.

---
 rtl/zap_wb_pkg.sv | 24 ++
 rtl/zap_wb_req_mux.sv | 13 +
 rtl/zap_mmu_wb_arbiter.sv | 110 +++++++++++
 tb/tb_zap_mmu_wb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_wb_pkg.sv
// Shared types for the MMU Wishbone arbiter: the bus owner, cycle-type codes
// and the packed request bundle carried from each master to the bus.
package zap_wb_pkg;

  typedef enum logic [0:0] {
    OWN_CACHE = 1'b0,
    OWN_TLB   = 1'b1
  } owner_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_BURST   = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        wen;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } wb_req_t;

endpackage

// File: rtl/zap_wb_req_mux.sv
// Combinational 2:1 selector between the cache and walker request bundles.
module zap_wb_req_mux
  import zap_wb_pkg::*;
(
  input  owner_t  sel,
  input  wb_req_t c_req,
  input  wb_req_t t_req,
  output wb_req_t req
);

  assign req = (sel == OWN_TLB) ? t_req : c_req;

endmodule

// File: rtl/zap_mmu_wb_arbiter.sv
// Merges the page-table walker and cache controller onto one Wishbone port,
// registering the selected master's next-state request so bursts stay whole.
module zap_mmu_wb_arbiter
  import zap_wb_pkg::*;
#(
  parameter bit TLB_PRIORITY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_c_wb_cyc_nxt,
  input  logic        i_c_wb_stb_nxt,
  input  logic        i_c_wb_wen_nxt,
  input  logic [3:0]  i_c_wb_sel_nxt,
  input  logic [31:0] i_c_wb_adr_nxt,
  input  logic [31:0] i_c_wb_dat_nxt,
  input  logic [2:0]  i_c_wb_cti_nxt,
  input  logic        i_t_wb_cyc_nxt,
  input  logic        i_t_wb_stb_nxt,
  input  logic [3:0]  i_t_wb_sel_nxt,
  input  logic [31:0] i_t_wb_adr_nxt,
  output logic        o_c_wb_ack,
  output logic        o_t_wb_ack,
  output logic [31:0] o_wb_dat_rd,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_wen,
  output logic [3:0]  o_wb_sel,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [2:0]  o_wb_cti,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_dat
);

  wb_req_t c_req;
  wb_req_t t_req;
  wb_req_t sel_req;
  wb_req_t bus_ff;
  owner_t  owner_ff;
  owner_t  owner_nxt;
  logic    own_cyc;
  logic    oth_cyc;

  always_comb begin
    c_req     = '0;
    c_req.cyc = i_c_wb_cyc_nxt;
    c_req.stb = i_c_wb_stb_nxt;
    c_req.wen = i_c_wb_wen_nxt;
    c_req.sel = i_c_wb_sel_nxt;
    c_req.adr = i_c_wb_adr_nxt;
    c_req.dat = i_c_wb_dat_nxt;
    c_req.cti = i_c_wb_cti_nxt;
  end

  // The walker only issues single-beat reads.
  always_comb begin
    t_req     = '0;
    t_req.cyc = i_t_wb_cyc_nxt;
    t_req.stb = i_t_wb_stb_nxt;
    t_req.wen = 1'b0;
    t_req.sel = i_t_wb_sel_nxt;
    t_req.adr = i_t_wb_adr_nxt;
    t_req.dat = '0;
    t_req.cti = CTI_EOB;
  end

  // Ownership moves only when the holder drops CYC; a fresh simultaneous
  // request on an idle bus is settled by TLB_PRIORITY.
  always_comb begin
    own_cyc   = (owner_ff == OWN_TLB) ? i_t_wb_cyc_nxt : i_c_wb_cyc_nxt;
    oth_cyc   = (owner_ff == OWN_TLB) ? i_c_wb_cyc_nxt : i_t_wb_cyc_nxt;
    owner_nxt = owner_ff;
    if (!bus_ff.cyc && i_c_wb_cyc_nxt && i_t_wb_cyc_nxt) begin
      owner_nxt = TLB_PRIORITY ? OWN_TLB : OWN_CACHE;
    end else if (!own_cyc && oth_cyc) begin
      owner_nxt = (owner_ff == OWN_TLB) ? OWN_CACHE : OWN_TLB;
    end
  end

  zap_wb_req_mux u_req_mux (
    .sel   (owner_nxt),
    .c_req (c_req),
    .t_req (t_req),
    .req   (sel_req)
  );

  // Register stage: bus request aligned with the granted master's own flops.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      owner_ff <= OWN_CACHE;
      bus_ff   <= '0;
    end else begin
      owner_ff <= owner_nxt;
      bus_ff   <= sel_req.cyc ? sel_req : '0;
    end
  end

  assign o_wb_cyc    = bus_ff.cyc;
  assign o_wb_stb    = bus_ff.stb;
  assign o_wb_wen    = bus_ff.wen;
  assign o_wb_sel    = bus_ff.sel;
  assign o_wb_adr    = bus_ff.adr;
  assign o_wb_dat    = bus_ff.dat;
  assign o_wb_cti    = bus_ff.cti;

  assign o_c_wb_ack  = i_wb_ack & (owner_ff == OWN_CACHE);
  assign o_t_wb_ack  = i_wb_ack & (owner_ff == OWN_TLB);
  assign o_wb_dat_rd = i_wb_dat;

endmodule

// File: tb/tb_zap_mmu_wb_arbiter.sv
// Bench for zap_mmu_wb_arbiter: per-cycle vector table, priority and reset
// sequences, then random two-master traffic against per-master address queues.
module tb_zap_mmu_wb_arbiter;
  import zap_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_cyc, c_stb, c_wen;
  logic [3:0]  c_sel;
  logic [31:0] c_adr, c_dat;
  logic [2:0]  c_cti;
  logic        t_cyc, t_stb;
  logic [3:0]  t_sel;
  logic [31:0] t_adr;
  logic        wb_ack;
  logic [31:0] wb_dat;

  logic        d1_cack, d1_tack, d1_cyc, d1_stb, d1_wen;
  logic [3:0]  d1_sel;
  logic [31:0] d1_rd, d1_adr, d1_dat;
  logic [2:0]  d1_cti;
  logic        d0_cack, d0_tack, d0_cyc, d0_stb, d0_wen;
  logic [3:0]  d0_sel;
  logic [31:0] d0_rd, d0_adr, d0_dat;
  logic [2:0]  d0_cti;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zap_mmu_wb_arbiter #(.TLB_PRIORITY(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_wen_nxt(c_wen),
    .i_c_wb_sel_nxt(c_sel), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
    .i_c_wb_cti_nxt(c_cti),
    .i_t_wb_cyc_nxt(t_cyc), .i_t_wb_stb_nxt(t_stb), .i_t_wb_sel_nxt(t_sel),
    .i_t_wb_adr_nxt(t_adr),
    .o_c_wb_ack(d1_cack), .o_t_wb_ack(d1_tack), .o_wb_dat_rd(d1_rd),
    .o_wb_cyc(d1_cyc), .o_wb_stb(d1_stb), .o_wb_wen(d1_wen), .o_wb_sel(d1_sel),
    .o_wb_adr(d1_adr), .o_wb_dat(d1_dat), .o_wb_cti(d1_cti),
    .i_wb_ack(wb_ack), .i_wb_dat(wb_dat)
  );

  zap_mmu_wb_arbiter #(.TLB_PRIORITY(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst),
    .i_c_wb_cyc_nxt(c_cyc), .i_c_wb_stb_nxt(c_stb), .i_c_wb_wen_nxt(c_wen),
    .i_c_wb_sel_nxt(c_sel), .i_c_wb_adr_nxt(c_adr), .i_c_wb_dat_nxt(c_dat),
    .i_c_wb_cti_nxt(c_cti),
    .i_t_wb_cyc_nxt(t_cyc), .i_t_wb_stb_nxt(t_stb), .i_t_wb_sel_nxt(t_sel),
    .i_t_wb_adr_nxt(t_adr),
    .o_c_wb_ack(d0_cack), .o_t_wb_ack(d0_tack), .o_wb_dat_rd(d0_rd),
    .o_wb_cyc(d0_cyc), .o_wb_stb(d0_stb), .o_wb_wen(d0_wen), .o_wb_sel(d0_sel),
    .o_wb_adr(d0_adr), .o_wb_dat(d0_dat), .o_wb_cti(d0_cti),
    .i_wb_ack(wb_ack), .i_wb_dat(wb_dat)
  );

  // One table row: inputs driven in a cycle, and the bus seen in that same
  // cycle (registered from the previous row) plus the combinational acks.
  typedef struct {
    logic        rst;
    logic        c_cyc;
    logic        c_wen;
    logic [31:0] c_adr;
    logic [31:0] c_dat;
    logic [2:0]  c_cti;
    logic        t_cyc;
    logic [31:0] t_adr;
    logic        ack;
    logic        e_cyc;
    logic        e_wen;
    logic [31:0] e_adr;
    logic [31:0] e_dat;
    logic [2:0]  e_cti;
    logic        e_cack;
    logic        e_tack;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(logic r, logic cc, logic cw, logic [31:0] ca,
                               logic [31:0] cd, logic [2:0] ct, logic tc,
                               logic [31:0] ta, logic ak, logic ec, logic ew,
                               logic [31:0] ea, logic [31:0] ed, logic [2:0] et,
                               logic eca, logic eta);
    vec_t v;
    v.rst = r; v.c_cyc = cc; v.c_wen = cw; v.c_adr = ca; v.c_dat = cd;
    v.c_cti = ct; v.t_cyc = tc; v.t_adr = ta; v.ack = ak;
    v.e_cyc = ec; v.e_wen = ew; v.e_adr = ea; v.e_dat = ed; v.e_cti = et;
    v.e_cack = eca; v.e_tack = eta;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic cc, input logic cw, input logic [31:0] ca,
                     input logic [31:0] cd, input logic [2:0] ct, input logic tc,
                     input logic [31:0] ta, input logic ak);
    rst = r;
    c_cyc = cc; c_stb = cc; c_wen = cw; c_sel = 4'hF; c_adr = ca; c_dat = cd; c_cti = ct;
    t_cyc = tc; t_stb = tc; t_sel = 4'hF; t_adr = ta;
    wb_ack = ak;
  endtask

  task automatic reset_all();
    @(negedge clk); drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Both masters request together from idle; the winner is acked and drops,
  // the loser holds and must follow with no bubble.
  task automatic prio_seq(input bit tlb_first);
    logic [31:0] adr_w, adr_l;
    string tag;
    tag   = tlb_first ? "prio1" : "prio0";
    adr_w = tlb_first ? 32'h0000_4020 : 32'h8000_0100;
    adr_l = tlb_first ? 32'h8000_0100 : 32'h0000_4020;
    reset_all();
    @(negedge clk); drv(0, 1, 0, 32'h8000_0100, 0, CTI_EOB, 1, 32'h0000_4020, 0);
    @(negedge clk); drv(0, tlb_first, 0, 32'h8000_0100, 0, CTI_EOB, !tlb_first, 32'h0000_4020, 1);
    #1;
    check({tag, " first adr"}, tlb_first ? d1_adr : d0_adr, adr_w);
    check({tag, " first c_ack"}, 32'(tlb_first ? d1_cack : d0_cack), 32'(!tlb_first));
    check({tag, " first t_ack"}, 32'(tlb_first ? d1_tack : d0_tack), 32'(tlb_first));
    @(negedge clk); drv(0, 0, 0, 32'h8000_0100, 0, CTI_EOB, 0, 32'h0000_4020, 1);
    #1;
    check({tag, " second adr"}, tlb_first ? d1_adr : d0_adr, adr_l);
    check({tag, " second c_ack"}, 32'(tlb_first ? d1_cack : d0_cack), 32'(tlb_first));
    check({tag, " second t_ack"}, 32'(tlb_first ? d1_tack : d0_tack), 32'(!tlb_first));
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check({tag, " idle cyc"}, 32'(tlb_first ? d1_cyc : d0_cyc), 0);
  endtask

  // Random-traffic state
  logic        rc_cyc, rc_wen;
  logic [31:0] rc_adr, rc_dat;
  logic [2:0]  rc_cti;
  int          rc_beats;
  logic        rt_cyc;
  logic [31:0] rt_adr;
  logic [31:0] c_q[$];
  logic [31:0] t_q[$];
  int          wcnt, lat;
  logic        s_ack, allow_new, drained;
  logic [31:0] exp_adr;

  initial begin
    // rst c_cyc c_wen c_adr c_dat c_cti t_cyc t_adr ack | e_cyc e_wen e_adr e_dat e_cti c_ack t_ack
    vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(1, 0, 0, 0, 0, 0, 0, 0, 1,                                   0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(row(0, 0, 1, 0, 32'hAAAA_5555, 0, 1, 32'h0000_4008, 0,           0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 0, 1, 0, 32'hAAAA_5555, 0, 1, 32'h0000_4008, 0,           1, 0, 32'h0000_4008, 0, 3'b111, 0, 0));
    vecs.push_back(row(0, 0, 1, 0, 32'hAAAA_5555, 0, 0, 32'h0000_4008, 1,           1, 0, 32'h0000_4008, 0, 3'b111, 0, 1));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 1,                                   0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(row(0, 1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b111, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 0, 1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b111, 0, 0, 1,      1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b111, 1, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, 0, 32'h8000_0000, 0, 3'b010, 0, 0, 0,                  0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 1, 0, 32'h8000_0004, 0, 3'b010, 0, 0, 1,                  1, 0, 32'h8000_0000, 0, 3'b010, 1, 0));
    vecs.push_back(row(0, 1, 0, 32'h8000_0008, 0, 3'b010, 0, 0, 1,                  1, 0, 32'h8000_0004, 0, 3'b010, 1, 0));
    vecs.push_back(row(0, 1, 0, 32'h8000_000C, 0, 3'b111, 1, 32'h0000_4010, 1,      1, 0, 32'h8000_0008, 0, 3'b010, 1, 0));
    vecs.push_back(row(0, 0, 0, 32'h8000_000C, 0, 3'b111, 1, 32'h0000_4010, 1,      1, 0, 32'h8000_000C, 0, 3'b111, 1, 0));
    vecs.push_back(row(0, 0, 1, 0, 32'hAAAA_5555, 0, 1, 32'h0000_4010, 0,           1, 0, 32'h0000_4010, 0, 3'b111, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 32'h0000_4010, 1,                       1, 0, 32'h0000_4010, 0, 3'b111, 0, 1));
    vecs.push_back(row(0, 0, 1, 32'h1234_5678, 32'h5555_AAAA, 3'b010, 0, 0, 0,      0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(row(0, 0, 0, 0, 0, 0, 0, 0, 0,                                   0, 0, 0, 0, 0, 0, 0));

    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    wb_dat = 0;
    @(negedge clk);
    @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drv(vecs[k].rst, vecs[k].c_cyc, vecs[k].c_wen, vecs[k].c_adr, vecs[k].c_dat,
          vecs[k].c_cti, vecs[k].t_cyc, vecs[k].t_adr, vecs[k].ack);
      wb_dat = 32'hC0DE_0000 + 32'(k);
      #1;
      check($sformatf("row%0d cyc", k), 32'(d1_cyc), 32'(vecs[k].e_cyc));
      check($sformatf("row%0d stb", k), 32'(d1_stb), 32'(vecs[k].e_cyc));
      check($sformatf("row%0d wen", k), 32'(d1_wen), 32'(vecs[k].e_wen));
      check($sformatf("row%0d sel", k), 32'(d1_sel), vecs[k].e_cyc ? 32'hF : 32'h0);
      check($sformatf("row%0d adr", k), d1_adr, vecs[k].e_adr);
      check($sformatf("row%0d dat", k), d1_dat, vecs[k].e_dat);
      check($sformatf("row%0d cti", k), 32'(d1_cti), 32'(vecs[k].e_cti));
      check($sformatf("row%0d c_ack", k), 32'(d1_cack), 32'(vecs[k].e_cack));
      check($sformatf("row%0d t_ack", k), 32'(d1_tack), 32'(vecs[k].e_tack));
      check($sformatf("row%0d rd_dat", k), d1_rd, 32'hC0DE_0000 + 32'(k));
    end

    prio_seq(1'b1);
    prio_seq(1'b0);

    // Reset in the middle of a cache burst
    reset_all();
    @(negedge clk); drv(0, 1, 0, 32'h8000_0200, 0, CTI_BURST, 0, 0, 0);
    @(negedge clk); drv(0, 1, 0, 32'h8000_0204, 0, CTI_BURST, 0, 0, 1);
    #1;
    check("rstburst beat0 adr", d1_adr, 32'h8000_0200);
    check("rstburst beat0 c_ack", 32'(d1_cack), 1);
    @(negedge clk); drv(1, 1, 0, 32'h8000_0204, 0, CTI_BURST, 0, 0, 0);
    #1;
    check("rstburst beat1 adr", d1_adr, 32'h8000_0204);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rstburst cyc", 32'(d1_cyc), 0);
    check("rstburst stb", 32'(d1_stb), 0);
    check("rstburst bus", {d1_wen, d1_sel, d1_cti, 24'h0} | d1_adr | d1_dat, 0);
    check("rstburst owner", 32'(dut1.owner_ff), 32'(OWN_CACHE));
    check("rstburst acks", 32'({d1_cack, d1_tack}), 0);
    @(negedge clk);
    #1;
    check("rstburst acks later", 32'({d1_cack, d1_tack}), 0);

    // Random interleaved traffic
    reset_all();
    rc_cyc = 0; rc_wen = 0; rc_adr = 0; rc_dat = 0; rc_cti = 0; rc_beats = 0;
    rt_cyc = 0; rt_adr = 0;
    wcnt = 0; lat = 1; drained = 0;
    for (int i = 0; i < 1700; i++) begin
      allow_new = (i < 1500);
      @(negedge clk);
      s_ack = 1'b0;
      if (d1_cyc && d1_stb) begin
        if (wcnt >= lat) begin
          s_ack = 1'b1;
          wcnt  = 0;
          lat   = int'($urandom_range(0, 2));
        end else begin
          wcnt++;
        end
      end
      wb_ack = s_ack;
      wb_dat = $urandom;
      #1;
      if (s_ack) begin
        check("rnd exactly one ack", 32'(d1_cack ^ d1_tack), 1);
        check("rnd rd_dat", d1_rd, wb_dat);
        if (d1_cack) begin
          check("rnd c queue nonempty", 32'(c_q.size() != 0), 1);
          exp_adr = (c_q.size() != 0) ? c_q.pop_front() : 32'hFFFF_FFFF;
          check("rnd c ack adr", d1_adr, exp_adr);
        end
        if (d1_tack) begin
          check("rnd t queue nonempty", 32'(t_q.size() != 0), 1);
          exp_adr = (t_q.size() != 0) ? t_q.pop_front() : 32'hFFFF_FFFF;
          check("rnd t ack adr", d1_adr, exp_adr);
        end
      end
      if (rc_cyc) begin
        if (d1_cack) begin
          if (rc_beats > 1) begin
            rc_beats--;
            rc_adr = rc_adr + 32'd4;
            rc_cti = (rc_beats == 1) ? CTI_EOB : CTI_BURST;
            c_q.push_back(rc_adr);
          end else begin
            rc_cyc = 1'b0;
          end
        end
      end else if (allow_new && $urandom_range(0, 3) == 0) begin
        rc_cyc   = 1'b1;
        rc_beats = int'($urandom_range(1, 4));
        rc_wen   = 1'($urandom_range(0, 1));
        rc_dat   = $urandom;
        rc_adr   = 32'h8000_0000 | ({20'h0, 12'($urandom)} << 4);
        rc_cti   = (rc_beats > 1) ? CTI_BURST : CTI_EOB;
        c_q.push_back(rc_adr);
      end
      if (rt_cyc) begin
        if (d1_tack) rt_cyc = 1'b0;
      end else if (allow_new && $urandom_range(0, 3) == 0) begin
        rt_cyc = 1'b1;
        rt_adr = 32'h0000_4000 | ({20'h0, 12'($urandom)} << 2);
        t_q.push_back(rt_adr);
      end
      drv(0, rc_cyc, rc_wen, rc_adr, rc_dat, rc_cti, rt_cyc, rt_adr, s_ack);
      if (!allow_new && !rc_cyc && !rt_cyc && !d1_cyc && c_q.size() == 0 && t_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check("rnd drained within budget", 32'(drained), 1);
    check("rnd c requests left", 32'(c_q.size()), 0);
    check("rnd t requests left", 32'(t_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
